// File: rtl/sc_microsequencer.sv
// Microcode sequencer for uDATAPATH: steps a loadable control-word program,
// branching on the datapath's active-low flags, with a start/done host handshake.
module sc_microsequencer #(
    parameter int unsigned DATAWIDTH_DECODER_SELECTION    = 3,
    parameter int unsigned DATAWIDTH_MUX_SELECTION        = 3,
    parameter int unsigned DATAWIDTH_ALU_SELECTION        = 4,
    parameter int unsigned DATAWIDTH_REGSHIFTER_SELECTION = 2,
    parameter int unsigned UPROG_ADDR_WIDTH               = 4,
    parameter int unsigned UWORD_WIDTH                    = 32,
    parameter logic [DATAWIDTH_DECODER_SELECTION-1:0] DECODER_NOP = 3'b111,
    parameter int unsigned MAX_STEPS                      = 255
) (
    input  logic                                      SC_MICROSEQUENCER_CLOCK_50,
    input  logic                                      SC_MICROSEQUENCER_RESET_InHigh,
    input  logic                                      SC_MICROSEQUENCER_start_In,
    input  logic [UPROG_ADDR_WIDTH-1:0]               SC_MICROSEQUENCER_startaddr_InBUS,
    input  logic                                      SC_MICROSEQUENCER_wren_In,
    input  logic [UPROG_ADDR_WIDTH-1:0]               SC_MICROSEQUENCER_wraddr_InBUS,
    input  logic [UWORD_WIDTH-1:0]                    SC_MICROSEQUENCER_wrdata_InBUS,
    input  logic                                      SC_MICROSEQUENCER_overflow_InLow,
    input  logic                                      SC_MICROSEQUENCER_carry_InLow,
    input  logic                                      SC_MICROSEQUENCER_negative_InLow,
    input  logic                                      SC_MICROSEQUENCER_zero_InLow,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_MICROSEQUENCER_decoderclearselection_OutBUS,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_MICROSEQUENCER_decoderloadselection_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_MICROSEQUENCER_muxselectionBUSA_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_MICROSEQUENCER_muxselectionBUSB_OutBUS,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_MICROSEQUENCER_aluselection_OutBUS,
    output logic                                      SC_MICROSEQUENCER_regSHIFTERclear_OutLow,
    output logic                                      SC_MICROSEQUENCER_regSHIFTERload_OutLow,
    output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_MICROSEQUENCER_regSHIFTERshiftselection_OutLow,
    output logic                                      SC_MICROSEQUENCER_busy_Out,
    output logic                                      SC_MICROSEQUENCER_done_Out,
    output logic                                      SC_MICROSEQUENCER_error_Out,
    output logic [UPROG_ADDR_WIDTH-1:0]               SC_MICROSEQUENCER_pc_OutBUS
);

    localparam int unsigned AW     = UPROG_ADDR_WIDTH;
    localparam int unsigned UW     = UWORD_WIDTH;
    localparam int unsigned DEPTH  = 1 << AW;
    localparam int unsigned FW     = 28;
    localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);
    localparam int unsigned DEC_W  = DATAWIDTH_DECODER_SELECTION;
    localparam int unsigned MUX_W  = DATAWIDTH_MUX_SELECTION;
    localparam int unsigned ALU_W  = DATAWIDTH_ALU_SELECTION;
    localparam int unsigned SH_W   = DATAWIDTH_REGSHIFTER_SELECTION;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] COND_NEVER  = 3'b000;
    localparam logic [2:0] COND_ALWAYS = 3'b001;
    localparam logic [2:0] COND_Z_SET  = 3'b010;
    localparam logic [2:0] COND_Z_CLR  = 3'b011;
    localparam logic [2:0] COND_C_SET  = 3'b100;
    localparam logic [2:0] COND_V_SET  = 3'b101;
    localparam logic [2:0] COND_N_SET  = 3'b110;
    localparam logic [2:0] COND_N_CLR  = 3'b111;

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              error_q, error_d;

    logic [FW-1:0]     mem [DEPTH];
    logic [FW-1:0]     word_q;

    logic              wr_en_c;
    logic              rd_en_c;
    logic              taken_c;
    logic              unused_reserved;

    logic [2:0]        w_clr, w_ld, w_muxa, w_muxb, w_cond;
    logic [3:0]        w_alu, w_target;
    logic              w_shclr_n, w_shld_n, w_end;
    logic [1:0]        w_shsel;

    // Bits above the control-word layout are reserved and never stored.
    assign unused_reserved = ^SC_MICROSEQUENCER_wrdata_InBUS[UW-1:FW];

    assign wr_en_c = SC_MICROSEQUENCER_wren_In && (state_q == ST_IDLE);
    assign rd_en_c = (state_q == ST_FETCH);

    // Program RAM: writes only in IDLE, synchronous read during FETCH.
    always_ff @(posedge SC_MICROSEQUENCER_CLOCK_50) begin
        if (wr_en_c) begin
            mem[SC_MICROSEQUENCER_wraddr_InBUS] <= SC_MICROSEQUENCER_wrdata_InBUS[FW-1:0];
        end
        if (rd_en_c) begin
            word_q <= mem[pc_q];
        end
    end

    assign w_clr     = word_q[27:25];
    assign w_ld      = word_q[24:22];
    assign w_muxa    = word_q[21:19];
    assign w_muxb    = word_q[18:16];
    assign w_alu     = word_q[15:12];
    assign w_shclr_n = word_q[11];
    assign w_shld_n  = word_q[10];
    assign w_shsel   = word_q[9:8];
    assign w_cond    = word_q[7:5];
    assign w_target  = word_q[4:1];
    assign w_end     = word_q[0];

    // Flags are only looked at for the data-dependent conditions.
    always_comb begin
        taken_c = 1'b0;
        case (w_cond)
            COND_NEVER:  taken_c = 1'b0;
            COND_ALWAYS: taken_c = 1'b1;
            COND_Z_SET:  taken_c = ~SC_MICROSEQUENCER_zero_InLow;
            COND_Z_CLR:  taken_c =  SC_MICROSEQUENCER_zero_InLow;
            COND_C_SET:  taken_c = ~SC_MICROSEQUENCER_carry_InLow;
            COND_V_SET:  taken_c = ~SC_MICROSEQUENCER_overflow_InLow;
            COND_N_SET:  taken_c = ~SC_MICROSEQUENCER_negative_InLow;
            COND_N_CLR:  taken_c =  SC_MICROSEQUENCER_negative_InLow;
            default:     taken_c = 1'b0;
        endcase
    end

    always_ff @(posedge SC_MICROSEQUENCER_CLOCK_50 or posedge SC_MICROSEQUENCER_RESET_InHigh) begin
        if (SC_MICROSEQUENCER_RESET_InHigh) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            step_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            step_q  <= step_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        step_d  = step_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (SC_MICROSEQUENCER_start_In) begin
                    pc_d    = SC_MICROSEQUENCER_startaddr_InBUS;
                    step_d  = '0;
                    error_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (w_end) begin
                    state_d = ST_DONE;
                end else if (step_q == STEP_W'(MAX_STEPS - 1)) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    pc_d    = taken_c ? AW'(w_target) : pc_q + AW'(1);
                    step_d  = step_q + STEP_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control word reaches the datapath only during EXEC; NOP otherwise.
    always_comb begin
        SC_MICROSEQUENCER_decoderclearselection_OutBUS    = DECODER_NOP;
        SC_MICROSEQUENCER_decoderloadselection_OutBUS     = DECODER_NOP;
        SC_MICROSEQUENCER_muxselectionBUSA_OutBUS         = '0;
        SC_MICROSEQUENCER_muxselectionBUSB_OutBUS         = '0;
        SC_MICROSEQUENCER_aluselection_OutBUS             = '0;
        SC_MICROSEQUENCER_regSHIFTERclear_OutLow          = 1'b1;
        SC_MICROSEQUENCER_regSHIFTERload_OutLow           = 1'b1;
        SC_MICROSEQUENCER_regSHIFTERshiftselection_OutLow = '0;
        if (state_q == ST_EXEC) begin
            SC_MICROSEQUENCER_decoderclearselection_OutBUS    = DEC_W'(w_clr);
            SC_MICROSEQUENCER_decoderloadselection_OutBUS     = DEC_W'(w_ld);
            SC_MICROSEQUENCER_muxselectionBUSA_OutBUS         = MUX_W'(w_muxa);
            SC_MICROSEQUENCER_muxselectionBUSB_OutBUS         = MUX_W'(w_muxb);
            SC_MICROSEQUENCER_aluselection_OutBUS             = ALU_W'(w_alu);
            SC_MICROSEQUENCER_regSHIFTERclear_OutLow          = w_shclr_n;
            SC_MICROSEQUENCER_regSHIFTERload_OutLow           = w_shld_n;
            SC_MICROSEQUENCER_regSHIFTERshiftselection_OutLow = SH_W'(w_shsel);
        end
    end

    assign SC_MICROSEQUENCER_busy_Out  = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign SC_MICROSEQUENCER_done_Out  = (state_q == ST_DONE);
    assign SC_MICROSEQUENCER_error_Out = error_q;
    assign SC_MICROSEQUENCER_pc_OutBUS = pc_q;

endmodule
